// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
//
// Truth-table sweep engine for a 2-input combinational gate cell.
//
// After a start request it walks {a,b} through 00, 01, 10, 11. Each vector
// is held for SETTLE_CYCLES clocks so the gate output can settle. y_in is
// then sampled for one clock and compared against EXPECT_TT[{a,b}].
// The per-vector mismatches are collected into fail_vec and err_count.
// pass is raised when all four vectors match.
//
// Parameters
//   SETTLE_CYCLES  clocks spent settling each vector before sampling (1..255)
//   EXPECT_TT      expected gate output, bit index = {a,b} (default XOR)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every output
//   start      one-cycle sweep request, honoured only while idle
//   abort      cancels a running sweep and clears the results
//   a_out      registered gate input a
//   b_out      registered gate input b
//   y_in       gate output, sampled in the clk domain
//   busy       high while a sweep is running
//   done       one-cycle pulse when a sweep finishes normally
//   pass       all four vectors matched; held until the next accepted start
//   err_count  number of mismatching vectors (0..4)
//   fail_vec   bit {a,b} set = that vector mismatched
// ---------------------------------------------------------------------------
module gate_sweep_checker #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECT_TT     = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  // The counter is loaded with S-1 and the state exits at zero, so exactly
  // S clocks are spent settling each vector.
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_reg;
  logic [1:0] idx_reg;
  logic [7:0] cnt_reg;

  logic       mismatch;
  logic [3:0] fail_hit;
  logic [3:0] fail_vec_next;

  assign mismatch = y_in ^ EXPECT_TT[idx_reg];

  // One-hot mark of the vector being sampled this cycle, if it mismatched.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fail_hit
      assign fail_hit[gi] = (state_reg == ST_SAMPLE) && (idx_reg == 2'(gi)) && mismatch;
    end
  endgenerate

  // The pass decision on the last vector has to include that vector's own
  // sample, so it uses the updated value of fail_vec.
  assign fail_vec_next = fail_vec | fail_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 2'd0;
      cnt_reg   <= 8'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      done <= 1'b0;

      if (abort && (state_reg != ST_IDLE)) begin
        // A cancelled sweep leaves no partial results behind.
        state_reg <= ST_IDLE;
        idx_reg   <= 2'd0;
        cnt_reg   <= 8'd0;
        {a_out, b_out} <= 2'b00;
        busy      <= 1'b0;
        pass      <= 1'b0;
        err_count <= 3'd0;
        fail_vec  <= 4'd0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // abort together with start suppresses the start.
            if (start && !abort) begin
              idx_reg        <= 2'd0;
              {a_out, b_out} <= 2'b00;
              fail_vec       <= 4'd0;
              err_count      <= 3'd0;
              pass           <= 1'b0;
              busy           <= 1'b1;
              cnt_reg        <= SETTLE_RELOAD;
              state_reg      <= ST_SETTLE;
            end
          end

          ST_SETTLE: begin
            if (cnt_reg == 8'd0) begin
              state_reg <= ST_SAMPLE;
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end

          ST_SAMPLE: begin
            fail_vec  <= fail_vec_next;
            err_count <= err_count + {2'b00, mismatch};
            if (idx_reg != 2'd3) begin
              idx_reg        <= idx_reg + 2'd1;
              {a_out, b_out} <= idx_reg + 2'd1;
              cnt_reg        <= SETTLE_RELOAD;
              state_reg      <= ST_SETTLE;
            end else begin
              idx_reg        <= 2'd0;
              {a_out, b_out} <= 2'b00;
              busy           <= 1'b0;
              done           <= 1'b1;
              pass           <= (fail_vec_next == 4'd0);
              state_reg      <= ST_IDLE;
            end
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
//
// The gate under test is modelled as a 4-bit truth table (gate_tt) that
// drives y_in from a_out/b_out combinationally. Expected sweep results are
// derived from the intended XOR behaviour: a vector fails when the gate's
// output differs from a^b. A fixed table of known gates is applied first,
// then random gates. Hand-written sequences cover mid-sweep start, start in
// the done cycle, abort, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;

  localparam int S     = 4;
  localparam int SWEEP = 4 * (S + 1);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       y_in;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  logic [3:0] gate_tt = 4'b0110;

  int vectors     = 0;
  int miscompares = 0;

  gate_sweep_checker #(
    .SETTLE_CYCLES(S),
    .EXPECT_TT    (4'b0110)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .a_out    (a_out),
    .b_out    (b_out),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  assign y_in = gate_tt[{a_out, b_out}];

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [3:0] exp_fail;
    logic [2:0] exp_err;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: vector {a,b} fails when the gate disagrees with a^b.
  function automatic logic [3:0] model_fail(input logic [3:0] tt);
    logic [3:0] f;
    f = 4'd0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] ab;
      ab = 2'(v);
      f[v] = (tt[v] != (ab[1] ^ ab[0]));
    end
    return f;
  endfunction

  function automatic logic [2:0] popc(input logic [3:0] f);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(f[i]);
    return 3'(n);
  endfunction

  // Runs one sweep from the start request through the done pulse, checking
  // the a/b walk and busy/done every cycle. Called right after an edge.
  task automatic run_sweep(input string name, input logic [3:0] tt,
                           input logic [3:0] exp_fail, input logic [2:0] exp_err,
                           input logic exp_pass, input bit extra_start, input bit chain);
    gate_tt = tt;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " start_busy"}, 32'(busy), 32'd1);
    check({name, " start_done"}, 32'(done), 32'd0);
    check({name, " start_ab"},   32'({a_out, b_out}), 32'd0);
    check({name, " start_clr"},  32'({pass, err_count, fail_vec}), 32'd0);
    for (int j = 1; j <= SWEEP; j++) begin
      if (extra_start && j == 7) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (j < SWEEP) begin
        check({name, " walk_ab"},   32'({a_out, b_out}), 32'(j / (S + 1)));
        check({name, " walk_busy"}, 32'(busy), 32'd1);
        check({name, " walk_done"}, 32'(done), 32'd0);
      end else begin
        check({name, " done"},      32'(done), 32'd1);
        check({name, " end_busy"},  32'(busy), 32'd0);
        check({name, " end_ab"},    32'({a_out, b_out}), 32'd0);
        check({name, " fail_vec"},  32'(fail_vec), 32'(exp_fail));
        check({name, " err_count"}, 32'(err_count), 32'(exp_err));
        check({name, " pass"},      32'(pass), 32'(exp_pass));
        check({name, " popcount"},  32'(err_count), 32'(popc(fail_vec)));
      end
    end
    $display("sweep %s tt=%b fail_vec=%b err_count=%0d pass=%0b",
             name, tt, fail_vec, err_count, pass);
    if (chain) begin
      start = 1'b1;
    end else begin
      @(posedge clk); #1;
      check({name, " done_drop"},   32'(done), 32'd0);
      check({name, " result_held"}, 32'({pass, err_count, fail_vec}),
            32'({exp_pass, exp_err, exp_fail}));
    end
  endtask

  initial begin
    tbl[0] = '{"xor",   4'b0110, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{"zero",  4'b0000, 4'b0110, 3'd2, 1'b0};
    tbl[2] = '{"one",   4'b1111, 4'b1001, 3'd2, 1'b0};
    tbl[3] = '{"and",   4'b1000, 4'b1110, 3'd3, 1'b0};
    tbl[4] = '{"or",    4'b1110, 4'b1000, 3'd1, 1'b0};
    tbl[5] = '{"nand",  4'b0111, 4'b0001, 3'd1, 1'b0};
    tbl[6] = '{"xnor",  4'b1001, 4'b1111, 3'd4, 1'b0};

    // Reset state
    #12;
    check("reset_outputs", 32'({a_out, b_out, busy, done, pass, err_count, fail_vec}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Table sweeps; entry 1 gets a stray start mid-sweep, entry 5 chains
    // straight into entry 6 by asserting start in the done cycle.
    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].name, tbl[i].tt, tbl[i].exp_fail, tbl[i].exp_err,
                tbl[i].exp_pass, (i == 1), (i == 5));
    end

    // Random gates against the reference model
    for (int r = 0; r < 10; r++) begin
      logic [3:0] tt;
      logic [3:0] ef;
      tt = 4'($urandom_range(0, 15));
      ef = model_fail(tt);
      run_sweep($sformatf("rand%0d", r), tt, ef, popc(ef), (ef == 4'd0),
                ($urandom_range(0, 3) == 0), (r % 3 == 1));
    end

    // abort in IDLE has no effect; abort together with start blocks the start
    run_sweep("pre_abort", 4'b0110, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    check("idle_abort_pass", 32'(pass), 32'd1);
    check("idle_abort_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_pass", 32'(pass), 32'd1);

    // abort during the settle of vector 2
    gate_tt = 4'b0000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * (S + 1) + 1) @(posedge clk);
    #1;
    check("pre_abort_ab",   32'({a_out, b_out}), 32'd2);
    check("pre_abort_fail", 32'(fail_vec), 32'b0010);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy",    32'(busy), 32'd0);
    check("abort_ab",      32'({a_out, b_out}), 32'd0);
    check("abort_results", 32'({done, pass, err_count, fail_vec}), 32'd0);
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 0; c < SWEEP + 5; c++) begin
        @(posedge clk); #1;
        if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
    end

    // Asynchronous reset between edges in the middle of a sweep
    gate_tt = 4'b0000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({a_out, b_out, busy, done, pass, err_count, fail_vec}), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(busy), 32'd0);
    run_sweep("post_reset", 4'b0110, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
